// File: rtl/seq_divider.sv
`default_nettype none
//============================================================================
// Module      : seq_divider
// Description : Multi-cycle unsigned restoring divider. One trial
//               subtraction per clock, WIDTH iterations per operation.
//               A zero divisor skips the iterations and reports
//               quotient = all ones, remainder = dividend.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   request pulse, accepted only while idle
//   dividend     in   [WIDTH] numerator, sampled on the accepting edge
//   divisor      in   [WIDTH] denominator, sampled on the accepting edge
//   busy         out  high while iterations are in progress
//   done         out  one-cycle pulse, results valid
//   quotient     out  [WIDTH] result quotient, held between operations
//   remainder    out  [WIDTH] result remainder, held between operations
//   div_by_zero  out  set with done when the divisor was zero
//
// Revision    : 1.0  initial release
//============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                 c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [WIDTH-1:0]   r_divisor;
    // Partial remainder. The arithmetic is WIDTH+1 bits wide, but the
    // stored value is always below the divisor, so its top bit is
    // always zero and is not kept.
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_q;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_by_zero;

    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_q_next;
    logic               w_last;

    // One restoring-division step: shift in the next dividend bit and
    // try to subtract the divisor; a borrow means restore.
    always_comb begin
        w_trial    = {r_rem, r_q[WIDTH-1]} - {1'b0, r_divisor};
        w_rem_next = w_trial[WIDTH-1:0];
        w_q_next   = {r_q[WIDTH-2:0], 1'b1};
        if (w_trial[WIDTH]) begin
            w_rem_next = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
            w_q_next   = {r_q[WIDTH-2:0], 1'b0};
        end
    end

    assign w_last = (r_cnt == c_last);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_next_state = (divisor == '0) ? c_st_done : c_st_run;
                end
            end
            c_st_run: begin
                if (w_last) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_done: w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_divisor     <= '0;
            r_rem         <= '0;
            r_q           <= '0;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Status flags follow the state being entered so that they
            // come straight from flops.
            r_busy  <= (w_next_state == c_st_run);
            r_done  <= (w_next_state == c_st_done);
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        if (divisor == '0) begin
                            r_quotient    <= '1;
                            r_remainder   <= dividend;
                            r_div_by_zero <= 1'b1;
                        end else begin
                            r_divisor <= divisor;
                            r_rem     <= '0;
                            r_q       <= dividend;
                            r_cnt     <= '0;
                        end
                    end
                end
                c_st_run: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (w_last) begin
                        r_quotient    <= w_q_next;
                        r_remainder   <= w_rem_next;
                        r_div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
//============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider (WIDTH = 32): a vector
//               table, hand-written corner sequences and a randomized
//               regression against an arithmetic reference model.
// Revision    : 1.0  initial release
//============================================================================
module tb_seq_divider;

    localparam int W       = 32;
    localparam int N_RAND  = 1500;
    localparam int TIMEOUT = 200;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dd;
        logic [W-1:0] dv;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: plain arithmetic, zero divisor handled explicitly.
    task automatic model(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int lat);
        if (dv == 0) begin
            q = '1; r = dd; z = 1'b1; lat = 1;
        end else begin
            q = dd / dv; r = dd % dv; z = 1'b0; lat = W + 1;
        end
    endtask

    // Issues one operation at the current negedge and follows it to done.
    // inj_at > 0 : pulse start with other operands in that cycle.
    // inj_at < 0 : pulse start (zero divisor) in the done cycle.
    // Returns positioned at the negedge of the cycle after done.
    task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv, input int inj_at,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                          output int lat, output logic busy_ok, output logic pulse_ok);
        logic d, b;
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        lat      = 0;
        busy_ok  = 1'b1;
        pulse_ok = 1'b1;
        q = '0; r = '0; z = 1'b0;
        forever begin
            @(negedge clk);
            lat++;
            d = done;
            b = busy;
            if (d) begin
                if (b) busy_ok = 1'b0;
                break;
            end
            if (b !== (dv != 0)) busy_ok = 1'b0;
            if (lat > TIMEOUT) break;
            start = (lat == inj_at);
            if (start) begin
                dividend = 32'd50;
                divisor  = 32'd5;
            end else begin
                dividend = $urandom;
                divisor  = $urandom;
            end
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
        if (inj_at < 0) begin
            start    = 1'b1;
            dividend = 32'd50;
            divisor  = 32'd0;
        end else begin
            start = 1'b0;
        end
        @(negedge clk);
        if (done || busy || quotient !== q || remainder !== r || div_by_zero !== z)
            pulse_ok = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [W-1:0] dd, input logic [W-1:0] dv,
                            input int inj_at, input logic use_exp,
                            input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        logic [W-1:0] q, r, mq, mr;
        logic         z, mz, bok, pok;
        int           lat, mlat;
        model(dd, dv, mq, mr, mz, mlat);
        if (use_exp) begin
            mq = eq; mr = er; mz = ez;
        end
        run_op(dd, dv, inj_at, q, r, z, lat, bok, pok);
        chk({tag, " quotient"},  64'(q),   64'(mq));
        chk({tag, " remainder"}, 64'(r),   64'(mr));
        chk({tag, " dbz"},       64'(z),   64'(mz));
        chk({tag, " latency"},   64'(lat), 64'(mlat));
        chk({tag, " busy"},      64'(bok), 64'd1);
        chk({tag, " pulse"},     64'(pok), 64'd1);
        if (dv != 0) begin
            chk({tag, " invariant"},
                64'((64'(q) * 64'(dv) + 64'(r) == 64'(dd)) && (r < dv)), 64'd1);
        end
    endtask

    initial begin
        logic [W-1:0] dd, dv;
        logic         seen;
        int           sel;

        rst = 1'b1; start = 1'b1; dividend = 32'd77; divisor = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst busy",      64'(busy),        64'd0);
        chk("rst done",      64'(done),        64'd0);
        chk("rst quotient",  64'(quotient),    64'd0);
        chk("rst remainder", 64'(remainder),   64'd0);
        chk("rst dbz",       64'(div_by_zero), 64'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,  1'b0};
        vecs[1]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,  1'b0};
        vecs[2]  = '{32'd3,          32'd10,         32'd0,          32'd3,  1'b0};
        vecs[3]  = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,  1'b1};
        vecs[4]  = '{32'd0,          32'd5,          32'd0,          32'd0,  1'b0};
        vecs[5]  = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,  1'b1};
        vecs[6]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,  1'b0};
        vecs[7]  = '{32'd7,          32'd7,          32'd1,          32'd0,  1'b0};
        vecs[8]  = '{32'd1000,       32'd9,          32'd111,        32'd1,  1'b0};
        vecs[9]  = '{32'd20,         32'd6,          32'd3,          32'd2,  1'b0};
        vecs[10] = '{32'h8000_0000,  32'd3,          32'd715827882,  32'd2,  1'b0};
        vecs[11] = '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFE, 1'b0};

        // Issued back to back: each start lands the cycle after done.
        for (int i = 0; i < 12; i++) begin
            check_op($sformatf("vec%0d", i), vecs[i].dd, vecs[i].dv, 0, 1'b1,
                     vecs[i].q, vecs[i].r, vecs[i].z);
        end

        // Start with new operands mid-operation is ignored.
        check_op("ign_run", 32'd1000, 32'd9, 10, 1'b1, 32'd111, 32'd1, 1'b0);
        repeat (5) @(negedge clk);
        chk("hold quotient",  64'(quotient),  64'd111);
        chk("hold remainder", 64'(remainder), 64'd1);

        // Start (zero divisor) in the done cycle is ignored.
        check_op("ign_done", 32'd100, 32'd7, -1, 1'b1, 32'd14, 32'd2, 1'b0);

        // Reset mid-operation aborts without a done.
        start = 1'b1; dividend = 32'd1000; divisor = 32'd9;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy",      64'(busy),        64'd0);
        chk("abort done",      64'(done),        64'd0);
        chk("abort quotient",  64'(quotient),    64'd0);
        chk("abort remainder", 64'(remainder),   64'd0);
        chk("abort dbz",       64'(div_by_zero), 64'd0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("abort quiet", 64'(seen), 64'd0);
        check_op("after_rst", 32'd20, 32'd6, 0, 1'b1, 32'd3, 32'd2, 1'b0);

        // Randomized regression against the model.
        for (int n = 0; n < N_RAND; n++) begin
            sel = $urandom_range(0, 15);
            dd  = $urandom;
            dv  = $urandom;
            case (sel)
                0:       dv = 32'd1;
                1:       dv = dd;
                2:       begin dd = $urandom_range(0, 1000); dv = dd + 32'd1 + $urandom_range(0, 1000); end
                3:       begin dd = '1; dv = $urandom_range(1, 100); end
                4:       dv = '1;
                5:       dv = 32'd0;
                6, 7:    dv = $urandom_range(1, 255);
                8:       dv = dv >> $urandom_range(1, 31);
                default: ;
            endcase
            check_op($sformatf("rand%0d", n), dd, dv, 0, 1'b0, '0, '0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
